tt_sel_ctrl: RTL
================

# tt_sel_ctrl

Wishbone-controlled sequencer that loads a new design-select index into the tile mux select chain inside `tt_top`. It asserts the design reset, serially shifts the index MSB-first, pulses the latch, holds reset for a fixed time and then releases it. It also exposes the committed index as `si_sel` for logic-analyzer readback. It sits in `user_project_wrapper` between the Wishbone slave port and `tt_top`, and replaces the constant Wishbone tie-offs.

## Interface
- `SEL_W`, 10, width of the design-select index.
- `CLK_DIV`, 4, `wb_clk_i` cycles per half-period of `sc_clk`; legal range ≥1.
- `RST_HOLD`, 16, cycles `des_rst_n` stays low after the latch pulse; legal range ≥1.

- `wb_clk_i` in 1: the single clock. All logic is clocked on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: Wishbone strobe, cycle and write-enable.
- `wbs_sel_i` in 4: byte selects.
- `wbs_adr_i` in 32: address; only bits [3:2] are decoded.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: registered acknowledge.
- `wbs_dat_o` out 32: read data.
- `sc_clk` out 1: select-chain shift clock.
- `sc_data` out 1: select-chain serial data.
- `sc_latch` out 1: select-chain parallel-load strobe.
- `des_rst_n` out 1: active-low reset to the selected design.
- `si_sel` out `SEL_W`: committed index.
- `busy` out 1: a sequence is in progress.
- `irq` out 1: level interrupt, equal to `done & irq_en`.

## Operation
- **Register map** (`wbs_adr_i[3:2]`):
  - 0 `SEL`: read/write, bits [`SEL_W`-1:0].
  - 1 `STATUS`: bit0 `busy` (read-only); bit1 `done` (sticky, write-1-to-clear); bit2 `ovr` (sticky, write-1-to-clear).
  - 2 `CTRL`: bit0 `irq_en` (read/write).
  - 3: reads 0; writes are ignored.
- **Byte selects:** a write takes effect only if `wbs_sel_i[0]` is set. For `SEL` with `SEL_W`>8, `wbs_sel_i[1]` must also be set. Unused read bits return 0.
- **`SEL` write while IDLE:** the data is captured into `req` and the FSM starts.
- **`SEL` write while not IDLE:** the write is ignored, `ovr` is set, and the write is still acked.
- **`SEL` read:** returns `si_sel`, the committed index, not `req`.
- **FSM states:** IDLE → ARST → SHIFT → LATCH → HOLD → IDLE.
  - **IDLE:** `sc_clk`=0, `sc_latch`=0, `des_rst_n`=1, `busy`=0.
  - **ARST:** lasts 1 cycle; `des_rst_n` goes low and stays low through HOLD.
  - **SHIFT:** `SEL_W` bits are sent, MSB first.
    - Each bit presents `sc_data`=`req[i]` with `sc_clk`=0 for `CLK_DIV` cycles, then `sc_clk`=1 for `CLK_DIV` cycles.
    - A bit counter counts down from `SEL_W`-1 to 0.
    - The transition to LATCH occurs after the high phase of bit 0.
  - **LATCH:** `sc_clk`=0 and `sc_latch`=1 for `CLK_DIV` cycles. `si_sel` is loaded with `req` on entry.
  - **HOLD:** `RST_HOLD` cycles.
  - **Exit to IDLE:** `des_rst_n` returns to 1 and `done` is set.
- **`sc_data`:** holds its last driven value when not in SHIFT.
- **Counters:**
  - A division counter of width clog2(`CLK_DIV`+1) reloads at every phase boundary.
  - A hold counter of width clog2(`RST_HOLD`+1).
  - No counter wraps; each one reloads on state entry.
- **Reset values:** all outputs and registers go to 0, except `des_rst_n`=1. The FSM returns to IDLE and `si_sel` becomes 0.
- **Reset mid-sequence:** the FSM aborts immediately. `si_sel` keeps only values committed before the reset; after reset it is 0. `des_rst_n` is released asynchronously.

## Timing
- **Wishbone ack:**
  - `wbs_ack_o` rises 1 cycle after `stb&cyc` is sampled high and is a single-cycle pulse.
  - No ack is given in the cycle directly after an ack, so back-to-back requests get ack every other cycle.
  - Read data is valid with the ack.
- **Sequence start:** a `SEL` write sampled at edge N moves the FSM to ARST at edge N+1, the same edge as the ack. `busy` is high from N+1.
- **Sequence length:** 1 + 2·`CLK_DIV`·`SEL_W` + `CLK_DIV` + `RST_HOLD` cycles; 101 cycles with default parameters.
  - `si_sel` updates at cycle 1+80 after ARST entry.
  - `busy` falls and `done` sets at cycle 101.
- **Same-cycle events:**
  - A W1C of `done` in the same cycle that `done` is set: the set wins.
  - A new `SEL` write in the cycle the FSM returns to IDLE is treated as not-IDLE: it is ignored and sets `ovr`.
- **`irq`:** combinational from registered bits, so it rises the cycle `done` sets when `irq_en`=1.

## Test plan
- **Reset:** hold `rst_n`=0 → `si_sel`=0, `busy`=0, `des_rst_n`=1, `wbs_ack_o`=0, `irq`=0.
- **Basic load:** write `SEL`=0x2A5 with defaults → `sc_data` carries bits 1,0,1,0,1,0,0,1,0,1 on 10 `sc_clk` rising edges spaced 8 cycles apart. Then `sc_latch` is high for 4 cycles, `si_sel`=0x2A5, `des_rst_n` is low for 101 cycles total, `done`=1 and `SEL` reads 0x2A5.
- **Overrun:** write `SEL`=0x001, then write `SEL`=0x3FF at cycle 20 → both writes are acked, `ovr`=1 and final `si_sel`=0x001.
- **Interrupt:** set `irq_en`=1 and load 0x3FF → `irq` rises with `done`. Writing `STATUS`=0x2 → `irq` falls the next cycle.
- **Reset mid-sequence:** pull `rst_n` low at cycle 50 of a load → `des_rst_n`=1 and `sc_clk`=0 immediately, and `si_sel`=0.
- **Parameter sweep:** `CLK_DIV`=1, `RST_HOLD`=1, load 0x155 → total sequence is 23 cycles and `si_sel`=0x155.

Source files
------------

// File: rtl/tt_sel_ctrl.sv
// Wishbone-controlled loader for the tile mux select chain: resets the design,
// shifts the new index MSB-first, latches it, holds reset, then releases it.
module tt_sel_ctrl #(
    parameter int SEL_W    = 10,
    parameter int CLK_DIV  = 4,
    parameter int RST_HOLD = 16
) (
    input  logic             wb_clk_i,
    input  logic             rst_n,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             sc_clk,
    output logic             sc_data,
    output logic             sc_latch,
    output logic             des_rst_n,
    output logic [SEL_W-1:0] si_sel,
    output logic             busy,
    output logic             irq
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int HLD_W = $clog2(RST_HOLD + 1);
    localparam int BIT_W = $clog2(SEL_W + 1);
    localparam logic [DIV_W-1:0] DIV_RLD = DIV_W'(CLK_DIV - 1);
    localparam logic [HLD_W-1:0] HLD_RLD = HLD_W'(RST_HOLD - 1);
    localparam bit NEED_B1 = (SEL_W > 8);

    typedef enum logic [2:0] {S_IDLE, S_ARST, S_SHIFT, S_LATCH, S_HOLD} state_t;

    state_t           r_state;
    logic             r_ack;
    logic [31:0]      r_dat;
    logic [SEL_W-1:0] r_req;
    logic [SEL_W-1:0] r_si_sel;
    logic [DIV_W-1:0] r_divcnt;
    logic [HLD_W-1:0] r_hold;
    logic [BIT_W-1:0] r_bitcnt;
    logic             r_sc_clk;
    logic             r_sc_data;
    logic             r_sc_latch;
    logic             r_des_rst_n;
    logic             r_done;
    logic             r_ovr;
    logic             r_irq_en;

    logic             w_req;
    logic             w_wr;
    logic             w_sel_wr;
    logic             w_busy;
    logic [1:0]       w_adr;
    logic [BIT_W-1:0] w_nbit;
    logic             w_unused;

    // No request is taken while the ack is out, so back-to-back cycles ack every other clock.
    assign w_req    = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_adr    = wbs_adr_i[3:2];
    assign w_wr     = w_req & wbs_we_i & wbs_sel_i[0];
    assign w_sel_wr = w_wr && (w_adr == 2'd0) && (!NEED_B1 || wbs_sel_i[1]);
    assign w_busy   = (r_state != S_IDLE);
    assign w_nbit   = r_bitcnt - 1'b1;
    assign w_unused = ^{wbs_adr_i, wbs_sel_i, wbs_dat_i};

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ack       <= 1'b0;
            r_dat       <= '0;
            r_req       <= '0;
            r_si_sel    <= '0;
            r_divcnt    <= '0;
            r_hold      <= '0;
            r_bitcnt    <= '0;
            r_sc_clk    <= 1'b0;
            r_sc_data   <= 1'b0;
            r_sc_latch  <= 1'b0;
            r_des_rst_n <= 1'b1;
            r_done      <= 1'b0;
            r_ovr       <= 1'b0;
            r_irq_en    <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_dat <= '0;
            if (w_req && !wbs_we_i) begin
                case (w_adr)
                    2'd0:    r_dat <= 32'(r_si_sel);
                    2'd1:    r_dat <= {29'd0, r_ovr, r_done, w_busy};
                    2'd2:    r_dat <= {31'd0, r_irq_en};
                    default: r_dat <= '0;
                endcase
            end
            if (w_wr && w_adr == 2'd1) begin
                if (wbs_dat_i[1]) r_done <= 1'b0;
                if (wbs_dat_i[2]) r_ovr  <= 1'b0;
            end
            if (w_wr && w_adr == 2'd2) r_irq_en <= wbs_dat_i[0];
            if (w_sel_wr && w_busy) r_ovr <= 1'b1;

            // Sticky sets below follow the W1C above so a same-cycle set wins.
            case (r_state)
                S_IDLE: if (w_sel_wr) begin
                    r_req       <= wbs_dat_i[SEL_W-1:0];
                    r_des_rst_n <= 1'b0;
                    r_state     <= S_ARST;
                end
                S_ARST: begin
                    r_sc_clk  <= 1'b0;
                    r_sc_data <= r_req[SEL_W-1];
                    r_bitcnt  <= BIT_W'(SEL_W - 1);
                    r_divcnt  <= DIV_RLD;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_divcnt != '0) begin
                        r_divcnt <= r_divcnt - 1'b1;
                    end else begin
                        r_divcnt <= DIV_RLD;
                        if (!r_sc_clk) begin
                            r_sc_clk <= 1'b1;
                        end else begin
                            r_sc_clk <= 1'b0;
                            if (r_bitcnt == '0) begin
                                r_sc_latch <= 1'b1;
                                r_si_sel   <= r_req;
                                r_state    <= S_LATCH;
                            end else begin
                                r_bitcnt  <= w_nbit;
                                r_sc_data <= r_req[w_nbit];
                            end
                        end
                    end
                end
                S_LATCH: begin
                    if (r_divcnt != '0) begin
                        r_divcnt <= r_divcnt - 1'b1;
                    end else begin
                        r_sc_latch <= 1'b0;
                        r_hold     <= HLD_RLD;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - 1'b1;
                    end else begin
                        r_des_rst_n <= 1'b1;
                        r_done      <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign sc_clk    = r_sc_clk;
    assign sc_data   = r_sc_data;
    assign sc_latch  = r_sc_latch;
    assign des_rst_n = r_des_rst_n;
    assign si_sel    = r_si_sel;
    assign busy      = w_busy;
    assign irq       = r_done & r_irq_en;
endmodule
